pfiform_gearbox: RTL and testbench

//  Parametrised byte-granular packing FIFO: successor to PFIFORM with generic lane count, width and depth.

---
 rtl/pfiform_pkg.sv | 16 +
 rtl/pfiform_rotate.sv | 24 ++
 rtl/pfiform_gearbox.sv | 188 ++++++++++++++++++
 tb/tb_pfiform_gearbox.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pfiform_pkg.sv
// Shared types and helpers for the byte-granular packing FIFO (pfiform_gearbox).
package pfiform_pkg;

    localparam int LANE_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Bits needed to hold a count in the range 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pfiform_rotate.sv
// Lane barrel rotator: output lane (i + shift) mod LANES takes input lane i.
module pfiform_rotate #(
    parameter int LANES  = 32,
    parameter int LANE_W = 8,
    parameter int SH_W   = $clog2(LANES)
) (
    input  logic [SH_W-1:0]         shift,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);

    localparam int W = LANES * LANE_W;

    // Logarithmic stages; LANES is a power of two so each stage is a plain rotate.
    always_comb begin
        dout = din;
        for (int b = 0; b < SH_W; b++) begin
            if (shift[b]) begin
                dout = (dout << ((1 << b) * LANE_W)) | (dout >> (W - (1 << b) * LANE_W));
            end
        end
    end

endmodule

// File: rtl/pfiform_gearbox.sv
// Byte-granular packing FIFO: variable-size joins and pops, flush/drain of partial remainders,
// registered level report and sticky protocol-error flag.
module pfiform_gearbox
    import pfiform_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int LANE_W = LANE_W_DEF,
    parameter int DEPTH  = 128
) (
    input  logic                       i_core_clk,
    input  logic                       i_rx_rst,
    input  logic                       i_flush,
    input  logic                       JoinEnable,
    output logic                       JoinPermit,
    input  logic [cnt_w(LANES)-1:0]    JoinAmount,
    input  logic [LANES*LANE_W-1:0]    JoinData,
    input  logic                       PopPermit,
    input  logic [cnt_w(LANES)-1:0]    PopAmount,
    output logic                       PopEnable,
    output logic [LANES*LANE_W-1:0]    PopData,
    output logic [cnt_w(LANES)-1:0]    PopCount,
    output logic [cnt_w(DEPTH)-1:0]    Level,
    output logic                       ProtErr
);

    localparam int W  = LANES * LANE_W;
    localparam int CW = cnt_w(LANES);
    localparam int LW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(LANES);
    localparam int NB = DEPTH / LANES;
    localparam int BW = $clog2(NB);

    localparam logic [CW-1:0] LANES_C  = CW'(LANES);
    localparam logic [LW:0]   ROOM_MAX = (LW + 1)'(DEPTH - LANES);

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          join_ok;
    logic          pop_ok;
    logic          join_fire;
    logic          pop_full;
    logic          pop_part;
    logic          pop_fire;
    logic          prot_hit;
    logic [CW-1:0] join_n;
    logic [CW-1:0] pop_n;

    // ---------------- request qualification (stage p0) ----------------
    assign JoinPermit = (state == IDLE) && ({1'b0, Level} <= ROOM_MAX);

    assign join_ok   = (JoinAmount != '0) && (JoinAmount <= LANES_C);
    assign pop_ok    = (PopAmount != '0) && (PopAmount <= LANES_C);
    assign join_fire = JoinEnable && JoinPermit && join_ok;

    assign pop_full  = PopPermit && pop_ok && (Level >= LW'(PopAmount));
    assign pop_part  = PopPermit && pop_ok && (state == DRAIN) && (Level != '0) &&
                       (Level < LW'(PopAmount));
    assign pop_fire  = pop_full || pop_part;

    // A partial pop only happens when Level < PopAmount <= LANES, so Level fits in CW bits.
    assign pop_n  = pop_full ? PopAmount : (pop_part ? Level[CW-1:0] : '0);
    assign join_n = join_fire ? JoinAmount : '0;

    assign prot_hit = (JoinEnable && (!JoinPermit || !join_ok)) || (PopPermit && !pop_ok);

    // ---------------- write alignment and banked storage ----------------
    logic [OW-1:0]              wr_off;
    logic [BW-1:0]              wr_bank;
    logic [W-1:0]               wr_rot_p0;
    logic [LANES-1:0]           wr_en_p0;
    logic [LANES-1:0][OW-1:0]   wr_k_p0;
    logic [LANES-1:0][BW-1:0]   wr_sel_p0;
    logic [LANE_W-1:0]          mem [NB][LANES];

    assign wr_off  = wr_ptr[OW-1:0];
    assign wr_bank = wr_ptr[PW-1:OW];

    pfiform_rotate #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .SH_W   (OW)
    ) u_wr_rot (
        .shift (wr_off),
        .din   (JoinData),
        .dout  (wr_rot_p0)
    );

    // Physical lanes below the start offset belong to the next bank (the wrap within a join).
    always_comb begin
        wr_en_p0  = '0;
        wr_k_p0   = '0;
        wr_sel_p0 = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_k_p0[l]   = OW'(l) - wr_off;
            wr_en_p0[l]  = join_fire && (int'(wr_k_p0[l]) < int'(JoinAmount));
            wr_sel_p0[l] = wr_bank + BW'(OW'(l) < wr_off);
        end
    end

    always_ff @(posedge i_core_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en_p0[l]) begin
                mem[wr_sel_p0[l]][l] <= wr_rot_p0[l*LANE_W +: LANE_W];
            end
        end
    end

    // ---------------- read alignment and lane mask ----------------
    logic [OW-1:0]              rd_off;
    logic [BW-1:0]              rd_bank;
    logic [OW-1:0]              rd_shift;
    logic [LANES-1:0][BW-1:0]   rd_sel_p0;
    logic [W-1:0]               rd_phys_p0;
    logic [W-1:0]               rd_rot_p0;
    logic [W-1:0]               rd_word_p0;

    assign rd_off   = rd_ptr[OW-1:0];
    assign rd_bank  = rd_ptr[PW-1:OW];
    assign rd_shift = OW'(0) - rd_off;

    always_comb begin
        rd_sel_p0  = '0;
        rd_phys_p0 = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_sel_p0[l] = rd_bank + BW'(OW'(l) < rd_off);
            rd_phys_p0[l*LANE_W +: LANE_W] = mem[rd_sel_p0[l]][l];
        end
    end

    pfiform_rotate #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .SH_W   (OW)
    ) u_rd_rot (
        .shift (rd_shift),
        .din   (rd_phys_p0),
        .dout  (rd_rot_p0)
    );

    always_comb begin
        rd_word_p0 = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(pop_n)) begin
                rd_word_p0[k*LANE_W +: LANE_W] = rd_rot_p0[k*LANE_W +: LANE_W];
            end
        end
    end

    // ---------------- output register (stage p1) ----------------
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            PopEnable <= 1'b0;
            PopCount  <= '0;
            PopData   <= '0;
        end else begin
            PopEnable <= pop_fire;
            PopCount  <= pop_n;
            if (pop_fire) begin
                PopData <= rd_word_p0;
            end
        end
    end

    // ---------------- control state: FSM, pointers, level, error ----------------
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Level   <= '0;
            ProtErr <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(join_n);
            rd_ptr  <= rd_ptr + PW'(pop_n);
            Level   <= Level + LW'(join_n) - LW'(pop_n);
            ProtErr <= ProtErr | prot_hit;
            case (state)
                IDLE:    if (i_flush && (Level != '0)) state <= DRAIN;
                DRAIN:   if (Level == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pfiform_gearbox.sv
// Scoreboard bench for pfiform_gearbox against a byte-queue reference model.
module tb_pfiform_gearbox;
    import pfiform_pkg::*;

    localparam int LANES  = 32;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 128;
    localparam int W      = LANES * LANE_W;
    localparam int CW     = cnt_w(LANES);
    localparam int LW     = cnt_w(DEPTH);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          flush = 1'b0;
    logic          je    = 1'b0;
    logic          jp;
    logic [CW-1:0] ja    = '0;
    logic [W-1:0]  jd    = '0;
    logic          pp    = 1'b0;
    logic [CW-1:0] pa    = '0;
    logic          pe;
    logic [W-1:0]  pd;
    logic [CW-1:0] pc;
    logic [LW-1:0] lvl;
    logic          perr;

    always #5 clk = ~clk;

    pfiform_gearbox #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
        .i_core_clk (clk),
        .i_rx_rst   (rst),
        .i_flush    (flush),
        .JoinEnable (je),
        .JoinPermit (jp),
        .JoinAmount (ja),
        .JoinData   (jd),
        .PopPermit  (pp),
        .PopAmount  (pa),
        .PopEnable  (pe),
        .PopData    (pd),
        .PopCount   (pc),
        .Level      (lvl),
        .ProtErr    (perr)
    );

    typedef struct {
        int           due;
        int           n;
        logic [W-1:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] store[$];
    bit         draining = 0;
    bit         m_perr   = 0;
    bit         chk_on   = 0;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit m_permit();
        return !draining && (DEPTH - store.size() >= LANES);
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input bit j_en, input int j_amt, input logic [W-1:0] j_dat,
                         input bit p_en, input int p_amt, input bit fl, input bit rs);
        int   s0;
        int   n;
        bit   perm;
        exp_t e;
        je = j_en; ja = CW'(j_amt); jd = j_dat;
        pp = p_en; pa = CW'(p_amt); flush = fl; rst = rs;
        perm = m_permit();
        check("level", W'(lvl), W'(store.size()));
        check("join_permit", W'(jp), W'(perm));
        check("prot_err", W'(perr), W'(m_perr));
        e.due = cyc + 1; e.n = 0; e.data = '0;
        if (rs) begin
            store.delete(); draining = 0; m_perr = 0;
        end else begin
            s0 = store.size();
            if (j_en && (!perm || j_amt < 1 || j_amt > LANES)) m_perr = 1;
            if (p_en && (p_amt < 1 || p_amt > LANES)) m_perr = 1;
            n = 0;
            if (p_en && p_amt >= 1 && p_amt <= LANES) begin
                if (s0 >= p_amt) n = p_amt;
                else if (draining && s0 > 0) n = s0;
            end
            e.n = n;
            for (int k = 0; k < n; k++) e.data[k*8 +: 8] = store.pop_front();
            if (j_en && perm && j_amt >= 1 && j_amt <= LANES)
                for (int k = 0; k < j_amt; k++) store.push_back(j_dat[k*8 +: 8]);
            if (!draining) begin
                if (fl && s0 != 0) draining = 1;
            end else if (s0 == 0) begin
                draining = 0;
            end
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, '0, 0, 1, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 1, '0, 0, 1, 0, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_on && expq.size() > 0) begin
            if (expq[0].due < cyc) begin
                e = expq.pop_front();
                check("pop_slot_missed", W'(expq.size() + 1), W'(0));
            end else if (expq[0].due == cyc) begin
                e = expq.pop_front();
                check("pop_enable", W'(pe), W'(e.n != 0));
                check("pop_count", W'(pc), W'(e.n));
                if (e.n != 0) check("pop_data", pd, e.data);
            end
        end
    end

    initial begin
        logic [W-1:0] w10;
        w10 = '0;
        for (int i = 0; i < 10; i++) w10[i*8 +: 8] = 8'(i);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;

        // Mid-stream reset with 40 bytes stored
        cycle(1, 32, rand_word(), 0, 1, 0, 0);
        cycle(1, 8, rand_word(), 0, 1, 0, 0);
        do_reset();
        idle(2);

        // Join 10 / pop 19 with a repeating 0..9 byte pattern
        for (int i = 0; i < 12; i++) cycle(1, 10, w10, 1, 19, 0, 0);
        idle(2);

        // Join 31 / pop 7 across the pointer wrap
        do_reset();
        for (int i = 0; i < 10 && m_permit(); i++) cycle(1, 31, rand_word(), 0, 7, 0, 0);
        for (int i = 0; i < 80; i++) cycle(m_permit(), 31, rand_word(), 1, 7, 0, 0);
        for (int i = 0; i < 25; i++) cycle(0, 1, '0, 1, 7, 0, 0);

        // Flush of 45 bytes with 32-byte pops
        do_reset();
        cycle(1, 32, rand_word(), 0, 32, 0, 0);
        cycle(1, 13, rand_word(), 0, 32, 0, 0);
        cycle(0, 1, '0, 1, 32, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, '0, 1, 32, 0, 0);

        // Same-cycle join and pop of 17 at Level 17
        do_reset();
        cycle(1, 17, rand_word(), 0, 17, 0, 0);
        cycle(1, 17, rand_word(), 1, 17, 0, 0);
        idle(2);

        // Randomised traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cycle(m_permit() && ($urandom_range(3) != 0), int'($urandom_range(LANES, 1)), rand_word(),
                  $urandom_range(2) != 0, int'($urandom_range(LANES, 1)),
                  $urandom_range(29) == 0, 0);
        end
        for (int i = 0; i < 30; i++) cycle(0, 1, '0, 1, 1, 1, 0);

        // Protocol errors: zero amount, join without permit, zero pop amount
        do_reset();
        cycle(1, 0, rand_word(), 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 32, rand_word(), 0, 1, 0, 0);
        idle(2);
        do_reset();
        cycle(0, 1, '0, 1, 0, 0, 0);
        idle(2);

        @(negedge clk);
        #1;
        check("queue_empty", W'(expq.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
